// File: rtl/dither_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dither_seq_ctrl
//  Description : Sequencer / supervisor for the PIG dither generator.
//                Decimates ADC strobes into generator triggers, shadows the
//                configuration and applies it on frame boundaries, republishes
//                frame results and restarts a stalled generator via watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module dither_seq_ctrl #(
    parameter logic [23:0] WDOG_CYC  = 24'd10_000_000,
    parameter logic [7:0]  RECOV_CYC = 8'd4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_adc_valid,
    input  logic [31:0] i_adc_data,
    input  logic        i_cfg_wr,
    input  logic [31:0] i_cfg_wait_cnt,
    input  logic [3:0]  i_cfg_avg_sel,
    input  logic [7:0]  i_cfg_decim,
    input  logic [31:0] i_dg_data,
    input  logic [31:0] i_dg_dither,
    output logic        o_dg_rst_n,
    output logic        o_dg_trig,
    output logic [31:0] o_dg_data,
    output logic [31:0] o_dg_wait_cnt,
    output logic [2:0]  o_dg_avg_sel,
    output logic [31:0] o_result,
    output logic        o_result_valid,
    output logic [15:0] o_frame_cnt,
    output logic        o_cfg_pending,
    output logic        o_wdog_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RUN     = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t      r_state;

    // Shadow configuration, written by the register bank at any time
    logic [7:0]  r_sh_decim;
    logic [31:0] r_sh_wait;
    logic [2:0]  r_sh_avg;

    // Applied decimation ratio (never zero) and sequencing counters
    logic [7:0]  r_decim;
    logic [7:0]  r_dec_cnt;
    logic [7:0]  r_recov_cnt;
    logic [23:0] r_wdog;
    logic        r_first_seen;
    logic        r_prev_neg;

    logic        w_boundary;
    logic        w_go_start;

    // A frame ends when the dither swings from negative to strictly positive
    assign w_boundary = r_prev_neg & ~i_dg_dither[31] & (|i_dg_dither);

    // Entering START either from IDLE or at the end of the recovery hold
    assign w_go_start = i_enable &
                        ((r_state == S_IDLE) ||
                         ((r_state == S_RECOVER) && (r_recov_cnt == RECOV_CYC - 8'd1)));

    // Capture configuration into the shadow; the generator only has 3 select
    // bits, so any larger averaging request saturates at 7
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_decim <= 8'd1;
            r_sh_wait  <= 32'd0;
            r_sh_avg   <= 3'd0;
        end else if (i_cfg_wr) begin
            r_sh_wait  <= i_cfg_wait_cnt;
            r_sh_avg   <= (i_cfg_avg_sel > 4'd7) ? 3'd7 : i_cfg_avg_sel[2:0];
            r_sh_decim <= (i_cfg_decim == 8'd0) ? 8'd1 : i_cfg_decim;
        end
    end

    // Remember the sign of the previous dither sample for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_neg <= 1'b0;
        end else begin
            r_prev_neg <= i_dg_dither[31];
        end
    end

    // Sequencer: state, decimation, frame publication and watchdog
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_decim        <= 8'd1;
            r_dec_cnt      <= 8'd0;
            r_recov_cnt    <= 8'd0;
            r_wdog         <= 24'd0;
            r_first_seen   <= 1'b0;
            o_dg_rst_n     <= 1'b0;
            o_dg_trig      <= 1'b0;
            o_dg_data      <= 32'd0;
            o_dg_wait_cnt  <= 32'd0;
            o_dg_avg_sel   <= 3'd0;
            o_result       <= 32'd0;
            o_result_valid <= 1'b0;
            o_frame_cnt    <= 16'd0;
            o_cfg_pending  <= 1'b0;
            o_wdog_err     <= 1'b0;
        end else begin
            o_dg_trig      <= 1'b0;
            o_result_valid <= 1'b0;

            // A config write acknowledges a previous timeout; a fresh timeout
            // in the same cycle is assigned later and wins
            if (i_cfg_wr) begin
                o_wdog_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    o_dg_rst_n <= 1'b0;
                    r_dec_cnt  <= 8'd0;
                    if (i_enable) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (!i_enable) begin
                        r_state    <= S_IDLE;
                        o_dg_rst_n <= 1'b0;
                    end else begin
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (!i_enable) begin
                        r_state    <= S_IDLE;
                        o_dg_rst_n <= 1'b0;
                        r_dec_cnt  <= 8'd0;
                    end else begin
                        if (i_adc_valid) begin
                            if (r_dec_cnt == r_decim - 8'd1) begin
                                o_dg_trig <= 1'b1;
                                o_dg_data <= i_adc_data;
                                r_dec_cnt <= 8'd0;
                            end else begin
                                r_dec_cnt <= r_dec_cnt + 8'd1;
                            end
                        end

                        // A boundary proves the generator is alive, so it
                        // takes precedence over an expiring watchdog
                        if (w_boundary) begin
                            r_wdog <= 24'd0;
                            if (!r_first_seen) begin
                                r_first_seen <= 1'b1;
                            end else begin
                                o_result       <= i_dg_data;
                                o_result_valid <= 1'b1;
                                o_frame_cnt    <= o_frame_cnt + 16'd1;
                                if (o_cfg_pending) begin
                                    o_dg_wait_cnt <= r_sh_wait;
                                    o_dg_avg_sel  <= r_sh_avg;
                                    r_decim       <= r_sh_decim;
                                    o_cfg_pending <= 1'b0;
                                end
                            end
                        end else if (r_wdog == WDOG_CYC - 24'd1) begin
                            r_state     <= S_RECOVER;
                            o_dg_rst_n  <= 1'b0;
                            o_wdog_err  <= 1'b1;
                            r_recov_cnt <= 8'd0;
                            r_dec_cnt   <= 8'd0;
                        end else begin
                            r_wdog <= r_wdog + 24'd1;
                        end
                    end
                end

                S_RECOVER: begin
                    if (!i_enable) begin
                        r_state <= S_IDLE;
                    end else if (r_recov_cnt == RECOV_CYC - 8'd1) begin
                        r_state <= S_START;
                    end else begin
                        r_recov_cnt <= r_recov_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    o_dg_rst_n <= 1'b0;
                end
            endcase

            // START outputs are registered on entry so the generator leaves
            // reset exactly when START begins
            if (w_go_start) begin
                o_dg_rst_n    <= 1'b1;
                o_dg_wait_cnt <= r_sh_wait;
                o_dg_avg_sel  <= r_sh_avg;
                r_decim       <= r_sh_decim;
                o_cfg_pending <= 1'b0;
                r_wdog        <= 24'd0;
                r_first_seen  <= 1'b0;
            end

            // A write that lands with an apply stays pending for next time
            if (i_cfg_wr) begin
                o_cfg_pending <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dither_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dither_seq_ctrl
//  Description : Self-checking bench for dither_seq_ctrl. The bench plays the
//                ADC front end, register bank and dither generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dither_seq_ctrl;

    localparam int WDOG  = 100;
    localparam int RECOV = 4;

    logic        clk = 1'b0;
    logic        rst, enable, adc_valid, cfg_wr;
    logic [31:0] adc_data, cfg_wait, dg_data, dg_dither;
    logic [3:0]  cfg_avg;
    logic [7:0]  cfg_decim;
    logic        o_dg_rst_n, o_dg_trig, o_result_valid, o_cfg_pending, o_wdog_err;
    logic [31:0] o_dg_data, o_dg_wait_cnt, o_result;
    logic [2:0]  o_dg_avg_sel;
    logic [15:0] o_frame_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dither_seq_ctrl #(
        .WDOG_CYC  (24'(WDOG)),
        .RECOV_CYC (8'(RECOV))
    ) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (enable),
        .i_adc_valid    (adc_valid),
        .i_adc_data     (adc_data),
        .i_cfg_wr       (cfg_wr),
        .i_cfg_wait_cnt (cfg_wait),
        .i_cfg_avg_sel  (cfg_avg),
        .i_cfg_decim    (cfg_decim),
        .i_dg_data      (dg_data),
        .i_dg_dither    (dg_dither),
        .o_dg_rst_n     (o_dg_rst_n),
        .o_dg_trig      (o_dg_trig),
        .o_dg_data      (o_dg_data),
        .o_dg_wait_cnt  (o_dg_wait_cnt),
        .o_dg_avg_sel   (o_dg_avg_sel),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_frame_cnt    (o_frame_cnt),
        .o_cfg_pending  (o_cfg_pending),
        .o_wdog_err     (o_wdog_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0; adc_valid = 1'b0; adc_data = 32'd0; cfg_wr = 1'b0;
        cfg_wait = 32'd0; cfg_avg = 4'd0; cfg_decim = 8'd1;
        dg_data = 32'd0; dg_dither = 32'd1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [31:0] w, input logic [3:0] a, input logic [7:0] d);
        cfg_wait = w; cfg_avg = a; cfg_decim = d; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic start_run();
        enable = 1'b1;
        tick(); tick();
    endtask

    // Generator select is 3 bits wide: requests above 7 saturate
    function automatic logic [2:0] clamp_avg(input logic [3:0] a);
        return (a > 4'd7) ? 3'd7 : a[2:0];
    endfunction

    task automatic test_reset();
        enable = 1'b1; adc_valid = 1'b1; adc_data = $urandom; cfg_wr = 1'b0;
        dg_dither = 32'd1; dg_data = $urandom; rst = 1'b1;
        tick(); tick();
        checks++; if (o_dg_rst_n !== 1'b0) begin errors++; $display("FAIL reset_rst_n: got %b expected 0", o_dg_rst_n); end
        checks++; if (o_dg_trig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b expected 0", o_dg_trig); end
        checks++; if (o_dg_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", o_dg_data); end
        checks++; if (o_dg_wait_cnt !== 32'd0) begin errors++; $display("FAIL reset_wait: got %0h expected 0", o_dg_wait_cnt); end
        checks++; if (o_dg_avg_sel !== 3'd0) begin errors++; $display("FAIL reset_avg: got %0d expected 0", o_dg_avg_sel); end
        checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %0h expected 0", o_result); end
        checks++; if (o_result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_result_valid); end
        checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d expected 0", o_frame_cnt); end
        checks++; if (o_cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", o_cfg_pending); end
        checks++; if (o_wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b expected 0", o_wdog_err); end
        // Default shadow: decimate by 1, wait 0, avg 0
        rst = 1'b0; adc_valid = 1'b0;
        start_run();
        checks++; if (o_dg_rst_n !== 1'b1) begin errors++; $display("FAIL default_rst_n: got %b expected 1", o_dg_rst_n); end
        for (int k = 0; k < 3; k++) begin
            adc_valid = 1'b1; adc_data = 32'(k + 7);
            tick();
            checks++; if (o_dg_trig !== 1'b1 || o_dg_data !== 32'(k + 7)) begin
                errors++; $display("FAIL default_decim k=%0d: got trig=%b data=%0d expected trig=1 data=%0d", k, o_dg_trig, o_dg_data, k + 7);
            end
        end
        adc_valid = 1'b0; enable = 1'b0;
        tick();
    endtask

    task automatic run_decim(input logic [7:0] dcfg, input logic [3:0] acfg, input int ncyc,
                             input bit rnd, output int pulses, output logic [31:0] last);
        int          eff, cnt;
        logic        v, exp_trig;
        logic [31:0] d, exp_data;
        do_reset();
        cfg_write(32'd0, acfg, dcfg);
        start_run();
        eff = (dcfg == 8'd0) ? 1 : int'(dcfg);
        checks++; if (o_dg_avg_sel !== clamp_avg(acfg)) begin errors++; $display("FAIL decim_avg: got %0d expected %0d", o_dg_avg_sel, clamp_avg(acfg)); end
        cnt = 0; exp_data = 32'd0; pulses = 0;
        for (int c = 0; c < ncyc; c++) begin
            v = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            d = rnd ? $urandom : 32'(c + 1);
            adc_valid = v; adc_data = d;
            tick();
            exp_trig = 1'b0;
            if (v) begin
                cnt++;
                if (cnt == eff) begin exp_trig = 1'b1; exp_data = d; cnt = 0; end
            end
            checks++; if (o_dg_trig !== exp_trig) begin errors++; $display("FAIL decim_trig c=%0d: got %b expected %b", c, o_dg_trig, exp_trig); end
            checks++; if (o_dg_data !== exp_data) begin errors++; $display("FAIL decim_data c=%0d: got %0h expected %0h", c, o_dg_data, exp_data); end
            if (o_dg_trig === 1'b1) pulses++;
        end
        adc_valid = 1'b0; enable = 1'b0;
        tick();
        last = o_dg_data;
    endtask

    task automatic test_decim();
        int p; logic [31:0] l;
        run_decim(8'd4, 4'd0, 8, 1'b0, p, l);
        checks++; if (p != 2) begin errors++; $display("FAIL decim4_pulses: got %0d expected 2", p); end
        checks++; if (l !== 32'd8) begin errors++; $display("FAIL decim4_last: got %0d expected 8", l); end
    endtask

    task automatic test_decim_random();
        int p; logic [31:0] l;
        for (int r = 0; r < 3; r++) begin
            run_decim(8'($urandom_range(1, 6)), 4'($urandom_range(0, 7)), 80, 1'b1, p, l);
        end
    endtask

    task automatic test_clamp();
        int p; logic [31:0] l;
        run_decim(8'd0, 4'd13, 20, 1'b0, p, l);
        checks++; if (p != 20) begin errors++; $display("FAIL clamp_pulses: got %0d expected 20", p); end
    endtask

    task automatic test_frame_basic();
        logic ev;
        do_reset();
        cfg_write(32'd2, 4'd1, 8'd1);
        start_run();
        checks++; if (o_dg_wait_cnt !== 32'd2 || o_dg_avg_sel !== 3'd1) begin
            errors++; $display("FAIL frame_cfg: got wait=%0d avg=%0d expected wait=2 avg=1", o_dg_wait_cnt, o_dg_avg_sel);
        end
        for (int c = 0; c < 14; c++) begin
            dg_dither = (((c / 3) % 2) == 0) ? -32'sd1 : 32'sd1;
            dg_data = (c == 9) ? 32'd2 : $urandom;
            tick();
            ev = (c == 9);
            checks++; if (o_result_valid !== ev) begin errors++; $display("FAIL frame_valid c=%0d: got %b expected %b", c, o_result_valid, ev); end
            if (c == 9) begin
                checks++; if (o_result !== 32'd2 || o_frame_cnt !== 16'd1) begin
                    errors++; $display("FAIL frame_result: got result=%0d frames=%0d expected result=2 frames=1", o_result, o_frame_cnt);
                end
            end
        end
        checks++; if (o_result !== 32'd2 || o_frame_cnt !== 16'd1) begin
            errors++; $display("FAIL frame_hold: got result=%0d frames=%0d expected result=2 frames=1", o_result, o_frame_cnt);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_cfg_pending();
        do_reset();
        cfg_write(32'd10, 4'd1, 8'd1);
        start_run();
        for (int c = 0; c < 40; c++) begin
            dg_dither = (((c / 4) % 2) == 0) ? -32'sd1 : 32'sd1;
            if (c == 15) begin cfg_wait = 32'd30; cfg_avg = 4'd3; cfg_wr = 1'b1; end
            if (c == 28) begin cfg_wait = 32'd40; cfg_avg = 4'd5; cfg_wr = 1'b1; end
            tick();
            cfg_wr = 1'b0;
            if (c >= 15 && c <= 19) begin
                checks++; if (o_dg_avg_sel !== 3'd1 || o_cfg_pending !== 1'b1) begin
                    errors++; $display("FAIL pend_hold c=%0d: got avg=%0d pend=%b expected avg=1 pend=1", c, o_dg_avg_sel, o_cfg_pending);
                end
            end
            if (c == 20) begin
                checks++; if (o_dg_avg_sel !== 3'd3 || o_dg_wait_cnt !== 32'd30 || o_cfg_pending !== 1'b0) begin
                    errors++; $display("FAIL pend_apply: got avg=%0d wait=%0d pend=%b expected avg=3 wait=30 pend=0", o_dg_avg_sel, o_dg_wait_cnt, o_cfg_pending);
                end
            end
            if (c == 28) begin
                checks++; if (o_dg_avg_sel !== 3'd3 || o_cfg_pending !== 1'b1) begin
                    errors++; $display("FAIL pend_sameedge: got avg=%0d pend=%b expected avg=3 pend=1", o_dg_avg_sel, o_cfg_pending);
                end
            end
            if (c == 36) begin
                checks++; if (o_dg_avg_sel !== 3'd5 || o_dg_wait_cnt !== 32'd40 || o_cfg_pending !== 1'b0) begin
                    errors++; $display("FAIL pend_apply2: got avg=%0d wait=%0d pend=%b expected avg=5 wait=40 pend=0", o_dg_avg_sel, o_dg_wait_cnt, o_cfg_pending);
                end
            end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_frames_random();
        logic [31:0] sh_wait, ap_wait, exp_res, w, dat;
        logic [2:0]  sh_avg, ap_avg;
        logic [3:0]  a;
        logic [15:0] frames;
        logic        first_seen, pending, prev_neg, cur_neg, wr, ev;
        int          hold;
        do_reset();
        start_run();
        sh_wait = 0; ap_wait = 0; sh_avg = 0; ap_avg = 0; exp_res = 0; frames = 0;
        first_seen = 0; pending = 0; prev_neg = 0; cur_neg = 0;
        hold = $urandom_range(1, 6);
        for (int c = 0; c < 300; c++) begin
            if (hold == 0) begin cur_neg = ~cur_neg; hold = $urandom_range(1, 6); end
            hold--;
            dat = $urandom; wr = ($urandom_range(0, 9) == 0); w = $urandom;
            a = 4'($urandom_range(0, 12));
            if (a > 4'd7) a = a + 4'd3;
            dg_dither = cur_neg ? -32'sd1 : 32'sd1; dg_data = dat;
            cfg_wr = wr; cfg_wait = w; cfg_avg = a; cfg_decim = 8'd1;
            tick();
            cfg_wr = 1'b0;
            ev = 1'b0;
            if (prev_neg && !cur_neg) begin
                if (!first_seen) first_seen = 1'b1;
                else begin
                    ev = 1'b1; exp_res = dat; frames++;
                    if (pending) begin ap_wait = sh_wait; ap_avg = sh_avg; pending = 1'b0; end
                end
            end
            if (wr) begin sh_wait = w; sh_avg = clamp_avg(a); pending = 1'b1; end
            prev_neg = cur_neg;
            checks++; if (o_result_valid !== ev) begin errors++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, o_result_valid, ev); end
            checks++; if (o_result !== exp_res) begin errors++; $display("FAIL rnd_result c=%0d: got %0h expected %0h", c, o_result, exp_res); end
            checks++; if (o_frame_cnt !== frames) begin errors++; $display("FAIL rnd_frames c=%0d: got %0d expected %0d", c, o_frame_cnt, frames); end
            checks++; if (o_cfg_pending !== pending) begin errors++; $display("FAIL rnd_pending c=%0d: got %b expected %b", c, o_cfg_pending, pending); end
            checks++; if (o_dg_wait_cnt !== ap_wait || o_dg_avg_sel !== ap_avg) begin
                errors++; $display("FAIL rnd_cfg c=%0d: got wait=%0h avg=%0d expected wait=%0h avg=%0d", c, o_dg_wait_cnt, o_dg_avg_sel, ap_wait, ap_avg);
            end
            checks++; if (o_dg_rst_n !== 1'b1) begin errors++; $display("FAIL rnd_rst_n c=%0d: got %b expected 1", c, o_dg_rst_n); end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        int n, low;
        do_reset();
        start_run();
        n = 0;
        while (o_dg_rst_n === 1'b1 && n < 300) begin tick(); n++; end
        checks++; if (n != WDOG) begin errors++; $display("FAIL wdog_timeout: got %0d cycles expected %0d", n, WDOG); end
        checks++; if (o_wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_err_set: got %b expected 1", o_wdog_err); end
        low = 0;
        while (o_dg_rst_n === 1'b0 && low < 50) begin low++; tick(); end
        checks++; if (low != RECOV) begin errors++; $display("FAIL wdog_recov_len: got %0d cycles expected %0d", low, RECOV); end
        checks++; if (o_wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_err_sticky: got %b expected 1", o_wdog_err); end
        cfg_write(32'd0, 4'd0, 8'd1);
        checks++; if (o_wdog_err !== 1'b0 || o_cfg_pending !== 1'b1) begin
            errors++; $display("FAIL wdog_err_clear: got err=%b pend=%b expected err=0 pend=1", o_wdog_err, o_cfg_pending);
        end
        // First boundary after START restarts the watchdog window
        do_reset();
        start_run();
        dg_dither = -32'sd1;
        repeat (50) tick();
        dg_dither = 32'sd1;
        tick();
        n = 0;
        while (o_dg_rst_n === 1'b1 && n < 300) begin tick(); n++; end
        checks++; if (n != WDOG) begin errors++; $display("FAIL wdog_bnd_clear: got %0d cycles expected %0d", n, WDOG); end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_enable_rst();
        do_reset();
        cfg_write(32'd5, 4'd2, 8'd1);
        start_run();
        for (int c = 0; c < 24; c++) begin
            dg_dither = (((c / 4) % 2) == 0) ? -32'sd1 : 32'sd1;
            dg_data = 32'h55AA_0000 + 32'(c);
            adc_valid = 1'b1; adc_data = 32'(c + 100);
            if (c == 22) begin cfg_avg = 4'd6; cfg_wait = 32'd9; cfg_wr = 1'b1; end
            tick();
            cfg_wr = 1'b0;
        end
        checks++; if (o_frame_cnt !== 16'd2 || o_cfg_pending !== 1'b1) begin
            errors++; $display("FAIL en_pre: got frames=%0d pend=%b expected frames=2 pend=1", o_frame_cnt, o_cfg_pending);
        end
        dg_dither = 32'sd1;
        enable = 1'b0;
        tick();
        checks++; if (o_dg_rst_n !== 1'b0 || o_dg_trig !== 1'b0) begin
            errors++; $display("FAIL en_drop: got rst_n=%b trig=%b expected rst_n=0 trig=0", o_dg_rst_n, o_dg_trig);
        end
        tick();
        checks++; if (o_dg_rst_n !== 1'b0 || o_dg_trig !== 1'b0) begin
            errors++; $display("FAIL en_idle: got rst_n=%b trig=%b expected rst_n=0 trig=0", o_dg_rst_n, o_dg_trig);
        end
        start_run();
        checks++; if (o_dg_rst_n !== 1'b1 || o_dg_avg_sel !== 3'd6 || o_cfg_pending !== 1'b0) begin
            errors++; $display("FAIL en_restart: got rst_n=%b avg=%0d pend=%b expected rst_n=1 avg=6 pend=0", o_dg_rst_n, o_dg_avg_sel, o_cfg_pending);
        end
        rst = 1'b1;
        tick();
        checks++; if (o_dg_rst_n !== 1'b0 || o_dg_trig !== 1'b0 || o_result_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctl: got rst_n=%b trig=%b valid=%b expected 0 0 0", o_dg_rst_n, o_dg_trig, o_result_valid);
        end
        checks++; if (o_dg_data !== 32'd0 || o_result !== 32'd0 || o_frame_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid_data: got data=%0h result=%0h frames=%0d expected 0 0 0", o_dg_data, o_result, o_frame_cnt);
        end
        checks++; if (o_dg_wait_cnt !== 32'd0 || o_dg_avg_sel !== 3'd0 || o_cfg_pending !== 1'b0 || o_wdog_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_cfg: got wait=%0h avg=%0d pend=%b err=%b expected 0 0 0 0", o_dg_wait_cnt, o_dg_avg_sel, o_cfg_pending, o_wdog_err);
        end
        rst = 1'b0; enable = 1'b0; adc_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_decim();
        test_decim_random();
        test_frame_basic();
        test_cfg_pending();
        test_frames_random();
        test_watchdog();
        test_clamp();
        test_enable_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
